fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 2, prefetch buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 EX_MEM_PCSrc  input  1  branch-taken redirect from MEM stage.
REQ-006 EX_MEM_NPC  input  32  redirect target PC.
REQ-007 ID_stall  input  1  decode cannot accept; IF/ID outputs hold.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  32  fetch byte address, word aligned.
REQ-010 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 IF_ID_instr  output  32  instruction to decode.
REQ-013 IF_ID_npc  output  32  fetched PC + 4.
REQ-014 IF_ID_valid  output  1  IF_ID_instr/IF_ID_npc carry a real instruction.

Function
REQ-015 SHALL hold a 32-bit PC; imem_addr SHALL equal PC whenever imem_req is 1.
REQ-016 SHALL allow at most one outstanding request; once raised, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-017 SHALL raise a new imem_req only in state RUN with FIFO count < 2 and no request outstanding, or in the cycle after an ack meeting the same conditions.
REQ-018 On an accepted ack in RUN: push {imem_rdata, PC+4} into the FIFO and set PC to PC+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-019 Output register update when ID_stall=0: FIFO non-empty -> pop head into IF_ID_instr/IF_ID_npc and set IF_ID_valid=1; FIFO empty -> IF_ID_instr=0 (NOP), IF_ID_npc unchanged, IF_ID_valid=0.
REQ-020 When ID_stall=1, IF_ID_* SHALL hold and the FIFO SHALL not pop.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, preserve FIFO order, and work at count 0 (no bypass) and count 2.
REQ-022 Latency: ack in cycle N, with no stall, gives IF_ID_valid=1 for that instruction after the edge ending cycle N+1.
REQ-023 States:
  RUN (normal);
  DRAIN (redirect taken while a request is outstanding and unacked).
REQ-024 Redirect (EX_MEM_PCSrc=1) SHALL take priority over stall, push and pop: PC <= EX_MEM_NPC, FIFO cleared, IF_ID_instr=0, IF_ID_valid=0 at the next edge.
REQ-025 Redirect with a request outstanding and imem_ack=0 SHALL enter DRAIN.
REQ-026 In DRAIN, imem_req SHALL stay high at the old address until ack; the ack data SHALL be discarded (no push, PC unchanged); the next state SHALL be RUN.
REQ-027 Redirect in the same cycle as imem_ack SHALL discard that data and stay in RUN.
REQ-028 A redirect while in DRAIN SHALL update PC to the new target and remain in DRAIN.
REQ-029 EX_MEM_NPC SHALL be used as-is; bits [1:0] SHALL be forced to 0 on imem_addr.

Reset
REQ-030 rst=0 SHALL immediately force PC=RESET_PC, state RUN, FIFO empty, imem_req=0, imem_addr=RESET_PC, IF_ID_instr=0, IF_ID_npc=0, IF_ID_valid=0.
REQ-031 Any outstanding request SHALL be abandoned on reset.
REQ-032 First imem_req=1 SHALL occur in the first cycle after rst deasserts.

Verification
REQ-033 Streaming: memory acks every cycle with rdata=addr, no stall -> IF_ID_npc sequence 4, 8, 12, ... with matching instr; IF_ID_valid continuous after fill.
REQ-034 Backpressure: ID_stall=1 for 5 cycles -> FIFO fills to 2, imem_req drops; IF_ID holds; after release, no instruction lost or duplicated.
REQ-035 Redirect during DRAIN: request to 0x10 outstanding, EX_MEM_PCSrc=1 with NPC=0x40, ack 3 cycles later -> ack data dropped, next request addr=0x40, first valid IF_ID_npc=0x44.
REQ-036 Simultaneous redirect and ack at 0x20, NPC=0x100 -> no push of 0x20 data, next imem_addr=0x100.
REQ-037 Wrap-around: RESET_PC=32'hFFFF_FFFC -> second fetch address 0; IF_ID_npc 0 then 4.
REQ-038 Mid-operation reset with FIFO full and a request pending -> all outputs at reset values within the same cycle; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a two-entry prefetch
// FIFO and the IF/ID pipeline register, with branch redirect and request draining.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_PCSrc,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        ID_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_npc,
    output logic        IF_ID_valid,
    output logic [0:0]  state_dbg
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [1:0] FULL  = 2'(FIFO_DEPTH);

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        busy;
    logic [63:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        req_core;
    logic        redirect;
    logic        acked;
    logic        push;
    logic        pop;

    // Handshake: imem_req/imem_addr are raised and then held unchanged until the
    // cycle in which imem_ack=1; that cycle completes the transfer and imem_rdata
    // is only looked at in it. A raised request is outstanding until acked.
    assign req_core  = busy | ((state == RUN) && (count < FULL));
    assign imem_req  = rst & req_core;
    assign imem_addr = busy ? req_addr : {pc[31:2], 2'b00};
    assign state_dbg = state;

    assign redirect = EX_MEM_PCSrc;
    assign acked    = req_core & imem_ack;
    assign push     = acked && (state == RUN) && !redirect;
    assign pop      = !redirect && !ID_stall && (count != 2'd0);

    // Data-only storage; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {imem_rdata, pc + 32'd4};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            busy        <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            IF_ID_instr <= 32'd0;
            IF_ID_npc   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else begin
            busy     <= req_core & ~imem_ack;
            req_addr <= imem_addr;
            if (redirect) begin
                // An unacked request cannot be withdrawn, so its data is drained later.
                pc          <= EX_MEM_NPC;
                state       <= (req_core && !imem_ack) ? DRAIN : RUN;
                wr_ptr      <= 1'b0;
                rd_ptr      <= 1'b0;
                count       <= 2'd0;
                IF_ID_instr <= 32'd0;
                IF_ID_valid <= 1'b0;
            end else begin
                if ((state == DRAIN) && acked) begin
                    state <= RUN;
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                    pc     <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
                if (!ID_stall) begin
                    if (count != 2'd0) begin
                        IF_ID_instr <= fifo_mem[rd_ptr][63:32];
                        IF_ID_npc   <= fifo_mem[rd_ptr][31:0];
                        IF_ID_valid <= 1'b1;
                    end else begin
                        IF_ID_instr <= 32'd0;
                        IF_ID_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
